mul_final_adder_pipe: RTL and testbench

Two-stage pipelined carry-propagate adder and normalizer for the mantissa multiplier. It sits directly downstream of the Wallace-tree reduction stages. It takes the final reduced sum row and carry row, resolves them into the full product, and emits a normalized mantissa with guard/round/sticky bits and an exponent-increment flag to the rounding stage. Transfers on both sides use a valid/ready handshake, with full backpressure support.

---
 rtl/mul_final_adder_pipe_if.sv | 33 +++
 rtl/mul_final_adder_pipe.sv | 105 ++++++++++
 tb/tb_mul_final_adder_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_final_adder_pipe_if.sv
// mul_final_adder_pipe_if: valid/ready bus between the Wallace-tree reduction stages, the
// final adder/normalizer and the rounding stage.
//   InValid/InReady/SumRow/CarryRow   : upstream transfer of one reduced sum/carry pair
//   OutValid/OutReady                 : downstream transfer of one normalized result
//   Product/Mantissa/Guard/Round/
//   Sticky/ExpInc                     : result fields
// Modports: slave is the adder's view, master is the view of the surrounding logic.
interface mul_final_adder_pipe_if #(
    parameter int unsigned W = 48
) ();
    logic           InValid;
    logic           InReady;
    logic [W-1:0]   SumRow;
    logic [W-1:0]   CarryRow;
    logic           OutValid;
    logic           OutReady;
    logic [W-1:0]   Product;
    logic [W/2-1:0] Mantissa;
    logic           Guard;
    logic           Round;
    logic           Sticky;
    logic           ExpInc;

    modport slave (
        input  InValid, SumRow, CarryRow, OutReady,
        output InReady, OutValid, Product, Mantissa, Guard, Round, Sticky, ExpInc
    );

    modport master (
        output InValid, SumRow, CarryRow, OutReady,
        input  InReady, OutValid, Product, Mantissa, Guard, Round, Sticky, ExpInc
    );
endinterface

// File: rtl/mul_final_adder_pipe.sv
// mul_final_adder_pipe: two-stage carry-propagate adder and normalizer for the mantissa
// multiplier. Stage 1 adds the low LO bits of the sum/carry rows and keeps the high slices;
// stage 2 finishes the high slice with the low carry, normalizes, and holds the result.
// Ports:
//   Clk   : rising-edge clock
//   Reset : synchronous active-high reset, empties the pipe and clears all registers
//   bus   : slave side of mul_final_adder_pipe_if (input pair handshake, result handshake)
module mul_final_adder_pipe #(
    parameter int unsigned W  = 48,
    parameter int unsigned LO = 24
) (
    input logic                   Clk,
    input logic                   Reset,
    mul_final_adder_pipe_if.slave bus
);
    localparam int unsigned H  = W / 2;
    localparam int unsigned HI = W - LO;

    logic          v1_q, v2_q;
    logic          adv1, adv2, in_ready;

    // Stage 1 registers
    logic          c1_q;
    logic [LO-1:0] s1lo_q;
    logic [HI-1:0] hi_s_q, hi_c_q;
    logic [LO:0]   lo_sum;

    // Stage 2 (output) registers and their next-state values
    logic [HI-1:0] hi_sum;
    logic [W-1:0]  prod_d, prod_q;
    logic [H-1:0]  mant_d, mant_q;
    logic          guard_d, guard_q;
    logic          round_d, round_q;
    logic          sticky_d, sticky_q;
    logic          exp_inc_d, exp_inc_q;

    always_comb begin
        adv2     = v1_q && (!v2_q || bus.OutReady);
        // Stage 1 frees up in the same cycle it hands over, so no bubble under full flow.
        in_ready = !Reset && (!v1_q || adv2);
        adv1     = bus.InValid && in_ready;
        lo_sum   = {1'b0, bus.SumRow[LO-1:0]} + {1'b0, bus.CarryRow[LO-1:0]};
    end

    always_comb begin
        // Carry out of the top bit is dropped: result is modulo 2^W.
        hi_sum    = hi_s_q + hi_c_q + {{(HI-1){1'b0}}, c1_q};
        prod_d    = {hi_sum, s1lo_q};
        exp_inc_d = prod_d[W-1];
        if (prod_d[W-1]) begin
            mant_d   = prod_d[W-1:H];
            guard_d  = prod_d[H-1];
            round_d  = prod_d[H-2];
            sticky_d = |prod_d[H-3:0];
        end else begin
            mant_d   = prod_d[W-2:H-1];
            guard_d  = prod_d[H-2];
            round_d  = prod_d[H-3];
            sticky_d = |prod_d[H-4:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            c1_q      <= 1'b0;
            s1lo_q    <= '0;
            hi_s_q    <= '0;
            hi_c_q    <= '0;
            prod_q    <= '0;
            mant_q    <= '0;
            guard_q   <= 1'b0;
            round_q   <= 1'b0;
            sticky_q  <= 1'b0;
            exp_inc_q <= 1'b0;
        end else begin
            v1_q <= adv1 | (v1_q & ~adv2);
            v2_q <= adv2 | (v2_q & ~bus.OutReady);
            if (adv1) begin
                c1_q   <= lo_sum[LO];
                s1lo_q <= lo_sum[LO-1:0];
                hi_s_q <= bus.SumRow[W-1:LO];
                hi_c_q <= bus.CarryRow[W-1:LO];
            end
            if (adv2) begin
                prod_q    <= prod_d;
                mant_q    <= mant_d;
                guard_q   <= guard_d;
                round_q   <= round_d;
                sticky_q  <= sticky_d;
                exp_inc_q <= exp_inc_d;
            end
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = v2_q;
    assign bus.Product  = prod_q;
    assign bus.Mantissa = mant_q;
    assign bus.Guard    = guard_q;
    assign bus.Round    = round_q;
    assign bus.Sticky   = sticky_q;
    assign bus.ExpInc   = exp_inc_q;
endmodule

// File: tb/tb_mul_final_adder_pipe.sv
// Self-checking bench for mul_final_adder_pipe (W=48, LO=24).
module tb_mul_final_adder_pipe;
    typedef struct packed {
        logic [47:0] p;
        logic [23:0] m;
        logic        g;
        logic        r;
        logic        s;
        logic        e;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    res_t exp_q[$];
    res_t obs_q[$];

    mul_final_adder_pipe_if #(.W(48)) bus ();

    mul_final_adder_pipe #(.W(48), .LO(24)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: full-width add, then pick the normalization shift from the top bit.
    function automatic res_t model(input logic [47:0] s, input logic [47:0] c);
        res_t        x;
        logic [48:0] full;
        logic [47:0] p;
        logic [47:0] mask;
        int          sh;
        full = {1'b0, s} + {1'b0, c};
        p    = full[47:0];
        sh   = p[47] ? 24 : 23;
        mask = (48'd1 << (sh - 2)) - 48'd1;
        x.p  = p;
        x.e  = p[47];
        x.m  = 24'(p >> sh);
        x.g  = p[sh-1];
        x.r  = p[sh-2];
        x.s  = (p & mask) != 48'd0;
        return x;
    endfunction

    function automatic res_t observed();
        res_t x;
        x.p = bus.Product;
        x.m = bus.Mantissa;
        x.g = bus.Guard;
        x.r = bus.Round;
        x.s = bus.Sticky;
        x.e = bus.ExpInc;
        return x;
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom), $urandom};
    endfunction

    // Transfer recorder used by the randomized test.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            obs_q.delete();
        end else begin
            if (bus.InValid && bus.InReady) exp_q.push_back(model(bus.SumRow, bus.CarryRow));
            if (bus.OutValid && bus.OutReady) obs_q.push_back(observed());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res_t zero_r;
        zero_r       = '0;
        reset        = 1'b1;
        bus.InValid  = 1'b1;
        bus.OutReady = 1'b1;
        bus.SumRow   = rnd48();
        bus.CarryRow = rnd48();
        step();
        step();
        @(negedge clk);
        checks++;
        if (bus.InReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_inready got=%b exp=0", bus.InReady);
        end
        checks++;
        if (bus.OutValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outvalid got=%b exp=0", bus.OutValid);
        end
        checks++;
        if (observed() !== zero_r) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", observed(), zero_r);
        end
        step();
        reset       = 1'b0;
        bus.InValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.OutValid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle cycle=%0d got=%b exp=0", i, bus.OutValid);
            end
            step();
        end
    endtask

    task automatic test_directed();
        logic [47:0] s_t[5];
        logic [47:0] c_t[5];
        res_t        r_t[5];
        s_t[0] = 48'h400000000000; c_t[0] = 48'h0;
        r_t[0] = {48'h400000000000, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0};
        s_t[1] = 48'h000000FFFFFF; c_t[1] = 48'h000000000001;
        r_t[1] = {48'h000001000000, 24'h000002, 1'b0, 1'b0, 1'b0, 1'b0};
        s_t[2] = 48'hFFFFFE000001; c_t[2] = 48'h0;
        r_t[2] = {48'hFFFFFE000001, 24'hFFFFFE, 1'b0, 1'b0, 1'b1, 1'b1};
        s_t[3] = 48'h800000000000; c_t[3] = 48'h800000000000;
        r_t[3] = {48'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        // All-ones low slices in both rows: carry must reach the high slice.
        s_t[4] = 48'h000000FFFFFF; c_t[4] = 48'h000000FFFFFF;
        r_t[4] = {48'h000001FFFFFE, 24'h000003, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.InValid  = 1'b1;
            bus.OutReady = 1'b1;
            bus.SumRow   = s_t[i];
            bus.CarryRow = c_t[i];
            step();
            bus.InValid = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.OutValid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_early_valid got=%b exp=0", i, bus.OutValid);
            end
            step();
            @(negedge clk);
            checks++;
            if (bus.OutValid !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_valid got=%b exp=1", i, bus.OutValid);
            end
            checks++;
            if (observed() !== r_t[i]) begin
                errors++;
                $display("FAIL dir%0d_result got=%h exp=%h", i, observed(), r_t[i]);
            end
            checks++;
            if (observed() !== model(s_t[i], c_t[i])) begin
                errors++;
                $display("FAIL dir%0d_model got=%h exp=%h", i, observed(),
                         model(s_t[i], c_t[i]));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] s_a[8];
        logic [47:0] c_a[8];
        for (int i = 0; i < 8; i++) begin
            s_a[i] = rnd48();
            c_a[i] = rnd48();
        end
        bus.OutReady = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.InValid = (k < 8);
            if (k < 8) begin
                bus.SumRow   = s_a[k];
                bus.CarryRow = c_a[k];
            end
            @(negedge clk);
            if (k >= 2) begin
                checks++;
                if (bus.OutValid !== 1'b1 || observed() !== model(s_a[k-2], c_a[k-2])) begin
                    errors++;
                    $display("FAIL b2b_out%0d got=%b/%h exp=1/%h", k - 2, bus.OutValid,
                             observed(), model(s_a[k-2], c_a[k-2]));
                end
            end
            step();
        end
        bus.InValid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic [47:0] s_a[4];
        logic [47:0] c_a[4];
        int          in_idx;
        int          out_idx;
        for (int i = 0; i < 4; i++) begin
            s_a[i] = rnd48();
            c_a[i] = rnd48();
        end
        bus.OutReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.InValid  = 1'b1;
            bus.SumRow   = s_a[(k < 2) ? k : 2];
            bus.CarryRow = c_a[(k < 2) ? k : 2];
            @(negedge clk);
            checks++;
            if (bus.InReady !== ((k < 2) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL bp_inready cycle=%0d got=%b exp=%b", k, bus.InReady, k < 2);
            end
            if (k >= 2) begin
                checks++;
                if (bus.OutValid !== 1'b1 || observed() !== model(s_a[0], c_a[0])) begin
                    errors++;
                    $display("FAIL bp_stall_hold cycle=%0d got=%b/%h exp=1/%h", k,
                             bus.OutValid, observed(), model(s_a[0], c_a[0]));
                end
            end
            step();
        end
        bus.OutReady = 1'b1;
        #1;
        checks++;
        if (bus.InReady !== 1'b1) begin
            errors++;
            $display("FAIL bp_inready_release got=%b exp=1", bus.InReady);
        end
        in_idx  = 2;
        out_idx = 0;
        for (int k = 0; k < 20; k++) begin
            bus.InValid = (in_idx < 4);
            if (in_idx < 4) begin
                bus.SumRow   = s_a[in_idx];
                bus.CarryRow = c_a[in_idx];
            end
            @(negedge clk);
            if (bus.OutValid && bus.OutReady) begin
                checks++;
                if (out_idx >= 4) begin
                    errors++;
                    $display("FAIL bp_extra_output got=%0d exp=4", out_idx + 1);
                end else if (observed() !== model(s_a[out_idx], c_a[out_idx])) begin
                    errors++;
                    $display("FAIL bp_order out%0d got=%h exp=%h", out_idx, observed(),
                             model(s_a[out_idx], c_a[out_idx]));
                end
                out_idx++;
            end
            if (bus.InValid && bus.InReady) in_idx++;
            step();
        end
        checks++;
        if (out_idx != 4) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=4", out_idx);
        end

        // Fill, then reset while full.
        bus.OutReady = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.InValid  = 1'b1;
            bus.SumRow   = rnd48();
            bus.CarryRow = rnd48();
            step();
        end
        @(negedge clk);
        checks++;
        if (bus.OutValid !== 1'b1 || bus.InReady !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got=%b%b exp=10", bus.OutValid, bus.InReady);
        end
        step();
        reset       = 1'b1;
        bus.InValid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b0) begin
            errors++;
            $display("FAIL bp_reset_flush got=%b%b exp=00", bus.OutValid, bus.InReady);
        end
        step();
        reset        = 1'b0;
        bus.OutReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.OutValid !== 1'b0) begin
                errors++;
                $display("FAIL bp_after_flush cycle=%0d got=%b exp=0", k, bus.OutValid);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic accepted;
        int   mode;
        exp_q.delete();
        obs_q.delete();
        accepted    = 1'b1;
        bus.InValid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!bus.InValid || accepted) begin
                bus.InValid = ($urandom_range(0, 3) != 0);
                mode        = $urandom_range(0, 3);
                case (mode)
                    0: begin bus.SumRow = rnd48(); bus.CarryRow = rnd48(); end
                    1: begin
                        bus.SumRow   = {rnd48() >> 24, 24'hFFFFFF};
                        bus.CarryRow = {24'(rnd48()), 24'(1 + $urandom_range(0, 3))};
                    end
                    2: begin bus.SumRow = ~48'h0; bus.CarryRow = 48'($urandom_range(0, 9)); end
                    default: begin bus.SumRow = rnd48() >> $urandom_range(0, 30);
                                   bus.CarryRow = rnd48() >> $urandom_range(0, 30); end
                endcase
            end
            bus.OutReady = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            accepted = bus.InValid && bus.InReady;
            step();
        end
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        for (int k = 0; k < 10; k++) step();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_item%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b0;
        bus.SumRow   = '0;
        bus.CarryRow = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
